// File: rtl/blake2_round_engine.sv
// blake2_round_engine
// Iterative BLAKE2 mixing core. One round is two cycles: four G lanes apply
// the column step, then the same four lanes apply the diagonal step. The word
// width and rotation amounts are parameters, so the same block serves
// BLAKE2s (W=32) and BLAKE2b (W=64).
module blake2_round_engine #(
  parameter int W      = 32,
  parameter int ROUNDS = 10,
  parameter int R1     = 16,
  parameter int R2     = 12,
  parameter int R3     = 8,
  parameter int R4     = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [16*W-1:0] v_i,
  input  logic [16*W-1:0] m_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [16*W-1:0] v_o
);

  // Round counter holds 0..ROUNDS, so it needs room for ROUNDS itself.
  localparam int RW = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COL  = 2'd1,
    DIAG = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    v_q [16];
  logic [W-1:0]    v_d [16];
  logic [W-1:0]    m_q [16];
  logic [W-1:0]    m_d [16];
  logic [RW-1:0]   round_q, round_d;
  logic [3:0]      sig_q, sig_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;

  logic [63:0]     srow;
  logic [4*W-1:0]  g_res  [4];
  logic [W-1:0]    col_v  [16];
  logic [W-1:0]    diag_v [16];

  // Message schedule ROM. One row per round (mod 10); position p of the row
  // sits in nibble (15-p), so the hex literal reads left to right as the table.
  function automatic logic [63:0] sigma_row(input logic [3:0] row);
    logic [63:0] r;
    case (row)
      4'd0:    r = 64'h0123456789ABCDEF;
      4'd1:    r = 64'hEA489FD61C02B753;
      4'd2:    r = 64'hB8C052FDAE367194;
      4'd3:    r = 64'h7931DCBE265A40F8;
      4'd4:    r = 64'h905724AFE1BC683D;
      4'd5:    r = 64'h2C6A0B834D75FE19;
      4'd6:    r = 64'hC51FED4A0763928B;
      4'd7:    r = 64'hDB7EC13950F4862A;
      4'd8:    r = 64'h6FE9B308C2D714A5;
      4'd9:    r = 64'hA2847615FB9E3CD0;
      default: r = 64'h0123456789ABCDEF;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W - n));
  endfunction

  // Full G: both half-mixes chained in one cycle; the second half sees the
  // updated a/b/c/d of the first. Result packed as {a, b, c, d}.
  function automatic logic [4*W-1:0] g_mix(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] d,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] a1, b1, c1, d1;
    logic [W-1:0] a2, b2, c2, d2;
    a1 = a + b + x;
    d1 = rotr(d ^ a1, R1);
    c1 = c + d1;
    b1 = rotr(b ^ c1, R2);
    a2 = a1 + b1 + y;
    d2 = rotr(d1 ^ a2, R3);
    c2 = c1 + d2;
    b2 = rotr(b1 ^ c2, R4);
    return {a2, b2, c2, d2};
  endfunction

  assign srow = sigma_row(sig_q);

  // Four G lanes. Lane gi always owns a = v[gi]; the b/c/d words and the
  // message pair switch between the column and diagonal quadruples.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam int CB = 4 + gi;
    localparam int CC = 8 + gi;
    localparam int CD = 12 + gi;
    localparam int DB = 4 + ((gi + 1) % 4);
    localparam int DC = 8 + ((gi + 2) % 4);
    localparam int DD = 12 + ((gi + 3) % 4);
    // Nibble offsets of schedule positions 2gi, 2gi+1 (column) and 8+2gi, 9+2gi (diagonal).
    localparam int CX = 15 - 2 * gi;
    localparam int CY = 14 - 2 * gi;
    localparam int DX = 7 - 2 * gi;
    localparam int DY = 6 - 2 * gi;

    logic         diag_sel;
    logic [3:0]   x_idx, y_idx;
    logic [W-1:0] b_sel, c_sel, d_sel;

    assign diag_sel = (state_q == DIAG);
    assign x_idx    = diag_sel ? srow[DX*4 +: 4] : srow[CX*4 +: 4];
    assign y_idx    = diag_sel ? srow[DY*4 +: 4] : srow[CY*4 +: 4];
    assign b_sel    = diag_sel ? v_q[DB] : v_q[CB];
    assign c_sel    = diag_sel ? v_q[DC] : v_q[CC];
    assign d_sel    = diag_sel ? v_q[DD] : v_q[CD];

    assign g_res[gi] = g_mix(v_q[gi], b_sel, c_sel, d_sel, m_q[x_idx], m_q[y_idx]);

    // Scatter lane results back to their vector slots for each step.
    assign col_v[gi]  = g_res[gi][4*W-1 -: W];
    assign col_v[CB]  = g_res[gi][3*W-1 -: W];
    assign col_v[CC]  = g_res[gi][2*W-1 -: W];
    assign col_v[CD]  = g_res[gi][W-1:0];
    assign diag_v[gi] = g_res[gi][4*W-1 -: W];
    assign diag_v[DB] = g_res[gi][3*W-1 -: W];
    assign diag_v[DC] = g_res[gi][2*W-1 -: W];
    assign diag_v[DD] = g_res[gi][W-1:0];
  end

  // Next-state logic: block capture, column/diagonal write-back, round count, output handshake.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    m_d     = m_q;
    round_d = round_q;
    sig_d   = sig_q;
    ready_d = ready_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (valid_i && ready_q) begin
          for (int k = 0; k < 16; k++) begin
            v_d[k] = v_i[k*W +: W];
            m_d[k] = m_i[k*W +: W];
          end
          round_d = '0;
          sig_d   = 4'd0;
          ready_d = 1'b0;
          state_d = COL;
        end
      end
      COL: begin
        v_d     = col_v;
        state_d = DIAG;
      end
      DIAG: begin
        v_d     = diag_v;
        round_d = round_q + RW'(1);
        sig_d   = (sig_q == 4'd9) ? 4'd0 : sig_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = COL;
        end
      end
      DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // Control and working-vector registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      round_q <= '0;
      sig_q   <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        v_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      sig_q   <= sig_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      v_q     <= v_d;
    end
  end

  // Message words are only meaningful after a capture, so they carry no reset.
  always_ff @(posedge clk) begin
    m_q <= m_d;
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;

  for (genvar gi = 0; gi < 16; gi++) begin : g_vout
    assign v_o[gi*W +: W] = v_q[gi];
  end

endmodule

// File: tb/tb_blake2_round_engine.sv
// tb_blake2_round_engine
// Scoreboard bench: a BLAKE2 software model fills a queue of expected vectors
// when a block is driven; results are popped and compared on each handshake.
`timescale 1ns/1ps
module tb_blake2_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         s_valid_i, s_ready_o, s_valid_o, s_ready_i;
  logic [511:0] s_v_i, s_m_i, s_v_o;

  logic          b_valid_i, b_ready_o, b_valid_o, b_ready_i;
  logic [1023:0] b_v_i, b_m_i, b_v_o;

  int checks = 0;
  int errors = 0;

  logic [511:0]  q32 [$];
  logic [1023:0] q64 [$];

  localparam logic [31:0] IV32 [8] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                                       32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};
  localparam logic [63:0] IV64 [8] = '{64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B,
                                       64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
                                       64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F,
                                       64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};

  localparam int SIGMA_T [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  // Quadruples for the eight G calls of a round: four columns, then four diagonals.
  localparam int GIDX [8][4] = '{
    '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}
  };

  blake2_round_engine #(.W(32), .ROUNDS(10), .R1(16), .R2(12), .R3(8), .R4(7)) dut_s (
    .clk(clk), .reset(reset),
    .valid_i(s_valid_i), .ready_o(s_ready_o), .v_i(s_v_i), .m_i(s_m_i),
    .valid_o(s_valid_o), .ready_i(s_ready_i), .v_o(s_v_o)
  );

  blake2_round_engine #(.W(64), .ROUNDS(12), .R1(32), .R2(24), .R3(16), .R4(63)) dut_b (
    .clk(clk), .reset(reset),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .v_i(b_v_i), .m_i(b_m_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .v_o(b_v_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_rotr(input logic [63:0] x, input int n, input int w);
    logic [31:0] x32;
    if (w == 32) begin
      x32 = x[31:0];
      return {32'd0, (x32 >> n) | (x32 << (32 - n))};
    end
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [255:0] ref_g(input logic [63:0] a0, input logic [63:0] b0,
                                         input logic [63:0] c0, input logic [63:0] d0,
                                         input logic [63:0] x, input logic [63:0] y, input int w);
    logic [63:0] mask, a, b, c, d;
    int r1, r2, r3, r4;
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    r1 = (w == 32) ? 16 : 32;
    r2 = (w == 32) ? 12 : 24;
    r3 = (w == 32) ? 8  : 16;
    r4 = (w == 32) ? 7  : 63;
    a = (a0 + b0 + x) & mask;
    d = ref_rotr((d0 ^ a) & mask, r1, w);
    c = (c0 + d) & mask;
    b = ref_rotr((b0 ^ c) & mask, r2, w);
    a = (a + b + y) & mask;
    d = ref_rotr((d ^ a) & mask, r3, w);
    c = (c + d) & mask;
    b = ref_rotr((b ^ c) & mask, r4, w);
    return {a, b, c, d};
  endfunction

  task automatic ref_compress(input int w, input int rounds, input logic [1023:0] vin,
                              input logic [1023:0] min, output logic [1023:0] vout);
    logic [63:0]  v [16];
    logic [63:0]  m [16];
    logic [255:0] r;
    int           row;
    for (int k = 0; k < 16; k++) begin
      v[k] = (w == 32) ? {32'd0, vin[k*32 +: 32]} : vin[k*64 +: 64];
      m[k] = (w == 32) ? {32'd0, min[k*32 +: 32]} : min[k*64 +: 64];
    end
    for (int rd = 0; rd < rounds; rd++) begin
      row = rd % 10;
      for (int i = 0; i < 8; i++) begin
        r = ref_g(v[GIDX[i][0]], v[GIDX[i][1]], v[GIDX[i][2]], v[GIDX[i][3]],
                  m[SIGMA_T[row][2*i]], m[SIGMA_T[row][2*i+1]], w);
        v[GIDX[i][0]] = r[255:192];
        v[GIDX[i][1]] = r[191:128];
        v[GIDX[i][2]] = r[127:64];
        v[GIDX[i][3]] = r[63:0];
      end
    end
    vout = '0;
    for (int k = 0; k < 16; k++) begin
      if (w == 32) vout[k*32 +: 32] = v[k][31:0];
      else         vout[k*64 +: 64] = v[k];
    end
  endtask

  function automatic int first_diff64(input logic [1023:0] a, input logic [1023:0] b);
    for (int k = 0; k < 16; k++) begin
      if (a[k*64 +: 64] !== b[k*64 +: 64]) return k;
    end
    return 0;
  endfunction

  // ---------------- drivers ----------------
  task automatic send32(input logic [511:0] v, input logic [511:0] m, output bit ok);
    logic [1023:0] e;
    ref_compress(32, 10, {512'd0, v}, {512'd0, m}, e);
    q32.push_back(e[511:0]);
    s_v_i = v;
    s_m_i = m;
    s_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = s_ready_o;
      @(posedge clk); #1;
    end
    s_valid_i = 1'b0;
  endtask

  task automatic send64(input logic [1023:0] v, input logic [1023:0] m, output bit ok);
    logic [1023:0] e;
    ref_compress(64, 12, v, m, e);
    q64.push_back(e);
    b_v_i = v;
    b_m_i = m;
    b_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = b_ready_o;
      @(posedge clk); #1;
    end
    b_valid_i = 1'b0;
  endtask

  // Cycle count starts at 1 on the acceptance edge.
  task automatic wait_valid32(output int cyc);
    cyc = 1;
    while (!s_valid_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_valid64(output int cyc);
    cyc = 1;
    while (!b_valid_o && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake32();
    s_ready_i = 1'b1;
    @(posedge clk); #1;
    s_ready_i = 1'b0;
  endtask

  task automatic rand_block(output logic [511:0] v, output logic [511:0] m);
    for (int k = 0; k < 16; k++) begin
      v[k*32 +: 32] = $urandom();
      m[k*32 +: 32] = $urandom();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    s_valid_i = 1'b0; s_ready_i = 1'b0; s_v_i = '0; s_m_i = '0;
    b_valid_i = 1'b0; b_ready_i = 1'b0; b_v_i = '0; b_m_i = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_s got %0b want 1", s_ready_o); end
    checks++; if (s_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_s got %0b want 0", s_valid_o); end
    checks++; if (s_v_o !== 512'd0) begin errors++; $display("FAIL reset_vo_s got %h want 0", s_v_o); end
    checks++; if (b_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_b got %0b want 1", b_ready_o); end
    checks++; if (b_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %0b want 0", b_valid_o); end
    checks++; if (b_v_o !== 1024'd0) begin errors++; $display("FAIL reset_vo_b got word0 %h want 0", b_v_o[63:0]); end
    $display("reset: ready_s=%0b valid_s=%0b ready_b=%0b valid_b=%0b", s_ready_o, s_valid_o, b_ready_o, b_valid_o);
  endtask

  task automatic test_zero_vector();
    bit ok;
    int cyc;
    logic [511:0] exp;
    send32('0, '0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_accept got 0 want 1"); end
    wait_valid32(cyc);
    checks++; if (cyc != 21) begin errors++; $display("FAIL zero_latency got %0d want 21", cyc); end
    checks++; if (s_v_o !== 512'd0) begin errors++; $display("FAIL zero_value got %h want 0", s_v_o); end
    exp = q32.pop_front();
    checks++; if (s_v_o !== exp) begin errors++; $display("FAIL zero_sb got %h want %h", s_v_o, exp); end
    handshake32();
    checks++; if (s_ready_o !== 1'b1 || s_valid_o !== 1'b0) begin
      errors++; $display("FAIL zero_release got ready=%0b valid=%0b want ready=1 valid=0", s_ready_o, s_valid_o);
    end
    $display("zero block: latency=%0d v_o=%h", cyc, s_v_o[31:0]);
  endtask

  task automatic test_blake2s_abc();
    bit ok;
    int cyc;
    logic [511:0] v, m, exp;
    logic [31:0] h0, h7, d0, d7;
    v = '0; m = '0;
    for (int k = 0; k < 8; k++) begin
      v[k*32 +: 32]     = IV32[k];
      v[(8+k)*32 +: 32] = IV32[k];
    end
    v[31:0]         = v[31:0] ^ 32'h01010020;
    v[12*32 +: 32]  = v[12*32 +: 32] ^ 32'd3;
    v[14*32 +: 32]  = v[14*32 +: 32] ^ 32'hFFFFFFFF;
    m[31:0]         = 32'h00636261;
    h0 = v[31:0];
    h7 = v[7*32 +: 32];
    send32(v, m, ok);
    checks++; if (!ok) begin errors++; $display("FAIL s_abc_accept got 0 want 1"); end
    wait_valid32(cyc);
    checks++; if (cyc != 21) begin errors++; $display("FAIL s_abc_latency got %0d want 21", cyc); end
    d0 = h0 ^ s_v_o[31:0] ^ s_v_o[8*32 +: 32];
    d7 = h7 ^ s_v_o[7*32 +: 32] ^ s_v_o[15*32 +: 32];
    checks++; if (d0 !== 32'h8C5E8C50) begin errors++; $display("FAIL s_abc_h0 got %h want 8c5e8c50", d0); end
    checks++; if (d7 !== 32'h82596786) begin errors++; $display("FAIL s_abc_h7 got %h want 82596786", d7); end
    exp = q32.pop_front();
    checks++; if (s_v_o !== exp) begin errors++; $display("FAIL s_abc_sb got %h want %h", s_v_o, exp); end
    handshake32();
    $display("blake2s abc: latency=%0d h0'=%h h7'=%h", cyc, d0, d7);
  endtask

  task automatic test_blake2b_abc();
    bit ok;
    int cyc;
    logic [1023:0] v, m, exp;
    logic [63:0] h0, d0;
    v = '0; m = '0;
    for (int k = 0; k < 8; k++) begin
      v[k*64 +: 64]     = IV64[k];
      v[(8+k)*64 +: 64] = IV64[k];
    end
    v[63:0]        = v[63:0] ^ 64'h0000_0000_0101_0040;
    v[12*64 +: 64] = v[12*64 +: 64] ^ 64'd3;
    v[14*64 +: 64] = v[14*64 +: 64] ^ 64'hFFFF_FFFF_FFFF_FFFF;
    m[63:0]        = 64'h0000_0000_0063_6261;
    h0 = v[63:0];
    send64(v, m, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b_abc_accept got 0 want 1"); end
    wait_valid64(cyc);
    checks++; if (cyc != 25) begin errors++; $display("FAIL b_abc_latency got %0d want 25", cyc); end
    d0 = h0 ^ b_v_o[63:0] ^ b_v_o[8*64 +: 64];
    checks++; if (d0 !== 64'h0D4D1C983FA580BA) begin errors++; $display("FAIL b_abc_h0 got %h want 0d4d1c983fa580ba", d0); end
    exp = q64.pop_front();
    checks++; if (b_v_o !== exp) begin
      errors++;
      $display("FAIL b_abc_sb word %0d got %h want %h", first_diff64(b_v_o, exp),
               b_v_o[first_diff64(b_v_o, exp)*64 +: 64], exp[first_diff64(b_v_o, exp)*64 +: 64]);
    end
    b_ready_i = 1'b1;
    @(posedge clk); #1;
    b_ready_i = 1'b0;
    checks++; if (b_ready_o !== 1'b1 || b_valid_o !== 1'b0) begin
      errors++; $display("FAIL b_abc_release got ready=%0b valid=%0b want ready=1 valid=0", b_ready_o, b_valid_o);
    end
    $display("blake2b abc: latency=%0d h0'=%h", cyc, d0);
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    logic [511:0] v, m, exp, snap;
    rand_block(v, m);
    send32(v, m, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept got 0 want 1"); end
    // A different block offered while busy must be ignored.
    s_v_i = ~v;
    s_m_i = m ^ 512'd1;
    s_valid_i = 1'b1;
    wait_valid32(cyc);
    checks++; if (cyc != 21) begin errors++; $display("FAIL bp_latency got %0d want 21", cyc); end
    snap = s_v_o;
    for (int i = 0; i < 5; i++) begin
      s_valid_i = i[0];
      @(posedge clk); #1;
      checks++;
      if (s_valid_o !== 1'b1 || s_ready_o !== 1'b0 || s_v_o !== snap) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%0b ready=%0b stable=%0b want valid=1 ready=0 stable=1",
                 i, s_valid_o, s_ready_o, s_v_o === snap);
      end
    end
    s_valid_i = 1'b0;
    exp = q32.pop_front();
    checks++; if (s_v_o !== exp) begin errors++; $display("FAIL bp_sb got %h want %h", s_v_o, exp); end
    handshake32();
    checks++; if (s_ready_o !== 1'b1 || s_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready=%0b valid=%0b want ready=1 valid=0", s_ready_o, s_valid_o);
    end
    $display("backpressure: held 5 cycles, released ready=%0b", s_ready_o);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    logic [511:0] v, m, exp;
    rand_block(v, m);
    send32(v, m, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_accept got 0 want 1"); end
    // Nine more edges lands in the diagonal step of round index 4.
    repeat (9) @(posedge clk);
    #1;
    checks++; if (s_ready_o !== 1'b0 || s_valid_o !== 1'b0) begin
      errors++; $display("FAIL rm_busy got ready=%0b valid=%0b want ready=0 valid=0", s_ready_o, s_valid_o);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(q32.pop_back());
    checks++; if (s_ready_o !== 1'b1 || s_valid_o !== 1'b0) begin
      errors++; $display("FAIL rm_after got ready=%0b valid=%0b want ready=1 valid=0", s_ready_o, s_valid_o);
    end
    checks++; if (s_v_o !== 512'd0) begin errors++; $display("FAIL rm_vo got %h want 0", s_v_o); end
    send32('0, '0, ok);
    wait_valid32(cyc);
    checks++; if (cyc != 21) begin errors++; $display("FAIL rm_latency got %0d want 21", cyc); end
    exp = q32.pop_front();
    checks++; if (s_v_o !== exp) begin errors++; $display("FAIL rm_sb got %h want %h", s_v_o, exp); end
    handshake32();
    $display("reset mid-round: recovered, fresh block latency=%0d", cyc);
  endtask

  task automatic test_back_to_back();
    logic [511:0] va, ma, vb, mb, exp;
    logic [1023:0] e;
    bit acc;
    int gap, busy_bad;
    rand_block(va, ma);
    rand_block(vb, mb);
    ref_compress(32, 10, {512'd0, va}, {512'd0, ma}, e);
    q32.push_back(e[511:0]);
    s_v_i = va; s_m_i = ma; s_valid_i = 1'b1; s_ready_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = s_ready_o;
      @(posedge clk); #1;
    end
    checks++; if (!acc) begin errors++; $display("FAIL b2b_accept_a got 0 want 1"); end
    // Second block queued behind the first with valid_i still high.
    s_v_i = vb; s_m_i = mb;
    ref_compress(32, 10, {512'd0, vb}, {512'd0, mb}, e);
    q32.push_back(e[511:0]);
    gap = 0; busy_bad = 0;
    while (!s_valid_o && gap < 200) begin
      if (s_ready_o) busy_bad++;
      @(posedge clk); #1;
      gap++;
    end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL b2b_busy_a got %0d ready cycles want 0", busy_bad); end
    exp = q32.pop_front();
    checks++; if (s_v_o !== exp) begin errors++; $display("FAIL b2b_sb_a got %h want %h", s_v_o, exp); end
    @(posedge clk); #1;
    gap++;
    checks++; if (s_ready_o !== 1'b1 || s_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got ready=%0b valid=%0b want ready=1 valid=0", s_ready_o, s_valid_o);
    end
    @(posedge clk); #1;
    gap++;
    s_valid_i = 1'b0;
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_accept_b got ready=%0b want 0", s_ready_o); end
    checks++; if (gap != 22) begin errors++; $display("FAIL b2b_period got %0d want 22", gap); end
    gap = 0; busy_bad = 0;
    while (!s_valid_o && gap < 200) begin
      if (s_ready_o) busy_bad++;
      @(posedge clk); #1;
      gap++;
    end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL b2b_busy_b got %0d ready cycles want 0", busy_bad); end
    exp = q32.pop_front();
    checks++; if (s_v_o !== exp) begin errors++; $display("FAIL b2b_sb_b got %h want %h", s_v_o, exp); end
    @(posedge clk); #1;
    s_ready_i = 1'b0;
    checks++; if (s_ready_o !== 1'b1 || s_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_release got ready=%0b valid=%0b want ready=1 valid=0", s_ready_o, s_valid_o);
    end
    $display("back-to-back: two blocks completed, queue left=%0d", q32.size());
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_blake2s_abc();
    test_blake2b_abc();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
